ref_beat_unpacker: RTL and testbench

- Sits between the AXI arbiter read-data port and the Engine's reference-load path.
- Takes a start command carrying a reference length in bases, then consumes 256-bit DRAM read beats (rd_data/rd_data_valid/rd_data_rdy).
- Emits one 2-bit base per cycle toward the PE array, with a last marker on the final base and a done pulse when the command completes.
- Gap-free: a new beat is accepted in the same cycle the last base of the current beat leaves.

---
 rtl/sw_pkg.sv | 18 +
 rtl/ref_beat_unpacker.sv | 131 +++++++++++++
 tb/tb_ref_beat_unpacker.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared constants and state encoding for the reference beat unpacker.
package sw_pkg;

  localparam int DATA_WIDTH = 256;
  localparam int BASE_WIDTH = 2;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

endpackage

// File: rtl/ref_beat_unpacker.sv
// Unpacks 256-bit DRAM read beats into a stream of 2-bit bases with last/done markers.
// Optional beat/command counters are built when REF_BEAT_UNPACKER_STATS_EN is defined.
module ref_beat_unpacker #(
  parameter int DATA_WIDTH = sw_pkg::DATA_WIDTH,
  parameter int BASE_WIDTH = sw_pkg::BASE_WIDTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  start_len_in,
  input  logic                  start_valid_in,
  output logic                  start_rdy_out,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  input  logic                  rd_data_valid_in,
  output logic                  rd_data_rdy_out,
  output logic [BASE_WIDTH-1:0] base_out,
  output logic                  base_valid_out,
  output logic                  base_last_out,
  input  logic                  base_rdy_in,
  output logic                  done_out
`ifdef REF_BEAT_UNPACKER_STATS_EN
  ,
  output logic [31:0]           stat_beats_out,
  output logic [31:0]           stat_cmds_out
`endif
);

  import sw_pkg::*;

  localparam int LANES  = DATA_WIDTH / BASE_WIDTH;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0]    LANE_MAX = LANE_W'(LANES - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] beat_q;
  logic [LANE_W-1:0]     lane_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  done_q;

  logic lastBase;
  logic lastLane;

  assign lastBase = (remain_q == LEN_ONE);
  assign lastLane = (lane_q == LANE_MAX);

  assign start_rdy_out  = (state_q == IDLE);
  assign base_valid_out = (state_q == DRAIN);
  assign base_last_out  = (state_q == DRAIN) && lastBase;
  assign base_out       = (state_q == DRAIN) ? beat_q[lane_q*BASE_WIDTH +: BASE_WIDTH] : '0;
  assign done_out       = done_q;

  // Mid-drain request only fires as the last lane leaves and more bases remain,
  // so the next beat lands with no bubble and never belongs to the next command.
  assign rd_data_rdy_out = (state_q == FETCH) ||
                           ((state_q == DRAIN) && base_rdy_in && lastLane && (remain_q > LEN_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      lane_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_valid_in) begin
            if (start_len_in == '0) begin
              done_q <= 1'b1;
            end else begin
              remain_q <= start_len_in;
              state_q  <= FETCH;
            end
          end
        end
        FETCH: begin
          if (rd_data_valid_in) begin
            beat_q  <= rd_data_in;
            lane_q  <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (base_rdy_in) begin
            remain_q <= remain_q - 1'b1;
            lane_q   <= lane_q + 1'b1;
            if (lastBase) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else if (lastLane) begin
              if (rd_data_valid_in) begin
                beat_q <= rd_data_in;
                lane_q <= '0;
              end else begin
                state_q <= FETCH;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef REF_BEAT_UNPACKER_STATS_EN
  logic [31:0] statBeats_q;
  logic [31:0] statCmds_q;
  logic        beatAccept;
  logic        cmdDone;

  assign beatAccept = rd_data_valid_in && rd_data_rdy_out;
  assign cmdDone    = ((state_q == IDLE) && start_valid_in && (start_len_in == '0)) ||
                      ((state_q == DRAIN) && base_rdy_in && lastBase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statBeats_q <= '0;
      statCmds_q  <= '0;
    end else begin
      if (beatAccept) statBeats_q <= statBeats_q + 32'd1;
      if (cmdDone)    statCmds_q  <= statCmds_q + 32'd1;
    end
  end

  assign stat_beats_out = statBeats_q;
  assign stat_cmds_out  = statCmds_q;
`endif

endmodule

// File: tb/tb_ref_beat_unpacker.sv
// Randomized bench for ref_beat_unpacker with a queue-based expected-base model.
// Stats counters are checked when REF_BEAT_UNPACKER_STATS_EN is defined.
`timescale 1ns/1ps
module tb_ref_beat_unpacker;
  import sw_pkg::*;

  localparam int LANES = DATA_WIDTH / BASE_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  start_len_in;
  logic         start_valid_in;
  logic         start_rdy_out;
  logic [255:0] rd_data_in;
  logic         rd_data_valid_in;
  logic         rd_data_rdy_out;
  logic [1:0]   base_out;
  logic         base_valid_out;
  logic         base_last_out;
  logic         base_rdy_in;
  logic         done_out;
`ifdef REF_BEAT_UNPACKER_STATS_EN
  logic [31:0]  stat_beats_out;
  logic [31:0]  stat_cmds_out;
`endif

  ref_beat_unpacker dut (
    .clk(clk), .rst(rst),
    .start_len_in(start_len_in), .start_valid_in(start_valid_in), .start_rdy_out(start_rdy_out),
    .rd_data_in(rd_data_in), .rd_data_valid_in(rd_data_valid_in), .rd_data_rdy_out(rd_data_rdy_out),
    .base_out(base_out), .base_valid_out(base_valid_out), .base_last_out(base_last_out),
    .base_rdy_in(base_rdy_in), .done_out(done_out)
`ifdef REF_BEAT_UNPACKER_STATS_EN
    , .stat_beats_out(stat_beats_out), .stat_cmds_out(stat_cmds_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: beats still to be supplied, and expected {last, base} stream
  logic [255:0] beatQ[$];
  logic [2:0]   expQ[$];
  bit   busy, doneExpect, startTaken, prevValid, prevRdy, prevLast, togg;
  logic [1:0] prevBase;
  int   curBeatsLeft, beatsTotal, cmdsDone, cycle, firstHs, lastHs;
  int   rdyMode, validMode, beatDelay, lastBeatsSeen, holdCnt;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Compare process: checks DUT against the model every cycle, then advances the
  // model for handshakes that will complete on the coming rising edge.
  always @(negedge clk) begin : cmp
    bit doneNext;
    cycle++;
    if (!rst) begin
      doneNext = 1'b0;
      checkOutput("start_rdy", start_rdy_out, !busy);
      checkOutput("done", done_out, doneExpect);
      if (doneExpect) cmdsDone++;
`ifdef REF_BEAT_UNPACKER_STATS_EN
      checkOutput("stat_beats", stat_beats_out, beatsTotal);
      checkOutput("stat_cmds", stat_cmds_out, cmdsDone);
`endif
      if (!busy) checkOutput("idle_valid", base_valid_out, 0);
      if (prevValid && !prevRdy) begin
        checkOutput("hold_valid", base_valid_out, 1);
        checkOutput("hold_base", base_out, prevBase);
        checkOutput("hold_last", base_last_out, prevLast);
      end
      if (base_valid_out) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_base", base_valid_out, 0);
        end else begin
          checkOutput("base", base_out, expQ[0][1:0]);
          checkOutput("last", base_last_out, expQ[0][2]);
          if (base_rdy_in) begin
            if (firstHs < 0) firstHs = cycle;
            lastHs = cycle;
            if (expQ[0][2]) begin
              busy = 1'b0;
              doneNext = 1'b1;
            end
            void'(expQ.pop_front());
          end
        end
      end
      if (rd_data_rdy_out) begin
        checkOutput("overfetch", curBeatsLeft > 0, 1);
        if (rd_data_valid_in && beatQ.size() > 0) begin
          void'(beatQ.pop_front());
          curBeatsLeft--;
          beatsTotal++;
        end
      end
      if (start_valid_in && start_rdy_out) begin
        startTaken = 1'b1;
        if (start_len_in == 16'd0) begin
          doneNext = 1'b1;
        end else begin
          busy = 1'b1;
          curBeatsLeft = (int'(start_len_in) + LANES - 1) / LANES;
        end
      end
      prevValid  = base_valid_out;
      prevRdy    = base_rdy_in;
      prevBase   = base_out;
      prevLast   = base_last_out;
      doneExpect = doneNext;
    end
  end

  // Input driver: presents queued beats and downstream ready per the active mode
  always @(posedge clk) begin
    #1;
    if (beatsTotal != lastBeatsSeen) begin
      lastBeatsSeen = beatsTotal;
      holdCnt = beatDelay;
    end
    if (holdCnt > 0) begin
      holdCnt--;
      rd_data_valid_in = 1'b0;
    end else begin
      rd_data_valid_in = (beatQ.size() > 0) && (validMode == 0 || $urandom_range(1, 0) == 1);
    end
    rd_data_in = (beatQ.size() > 0) ? beatQ[0] : {8{$urandom}};
    togg = ~togg;
    case (rdyMode)
      0:       base_rdy_in = 1'b1;
      1:       base_rdy_in = togg;
      default: base_rdy_in = ($urandom_range(3, 0) != 0);
    endcase
  end

  task automatic waitIdle(input int maxc);
    int n;
    n = 0;
    while ((busy || expQ.size() != 0 || doneExpect) && n < maxc) begin
      @(posedge clk);
      n++;
    end
    if (n >= maxc) checkOutput("idle_timeout", busy, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic applyStimulus(input int len, input bit waitDone, input bit pinned);
    logic [255:0] beats[$];
    int nb, n, s;
    nb = (len + LANES - 1) / LANES;
    for (int k = 0; k < nb; k++) begin
      logic [255:0] b;
      b = {8{$urandom}};
      if (pinned && k == 0) b[9:0] = 10'b11_10_01_00_11;
      beats.push_back(b);
      beatQ.push_back(b);
    end
    s = expQ.size();
    for (int i = 0; i < len; i++) begin
      logic [255:0] b;
      b = beats[i / LANES];
      expQ.push_back({(i == len - 1), b[2*(i % LANES) +: 2]});
    end
    if (pinned) begin
      checkOutput("model_b0", expQ[s][1:0], 3);
      checkOutput("model_b1", expQ[s+1][1:0], 0);
      checkOutput("model_b2", expQ[s+2][1:0], 1);
      checkOutput("model_b3", expQ[s+3][1:0], 2);
      checkOutput("model_b4", expQ[s+4][1:0], 3);
      checkOutput("model_last3", expQ[s+3][2], 0);
      checkOutput("model_last4", expQ[s+4][2], 1);
    end
    @(posedge clk);
    #1;
    startTaken     = 1'b0;
    start_len_in   = len[15:0];
    start_valid_in = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!startTaken && n < 5000);
    if (!startTaken) checkOutput("start_timeout", startTaken, 1);
    #1;
    start_valid_in = 1'b0;
    if (waitDone) waitIdle(20000);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_start_rdy", start_rdy_out, 1);
    checkOutput("rst_rd_rdy", rd_data_rdy_out, 0);
    checkOutput("rst_valid", base_valid_out, 0);
    checkOutput("rst_last", base_last_out, 0);
    checkOutput("rst_base", base_out, 0);
    checkOutput("rst_done", done_out, 0);
    expQ.delete();
    beatQ.delete();
    busy = 0; doneExpect = 0; prevValid = 0; curBeatsLeft = 0;
    beatsTotal = 0; cmdsDone = 0; start_valid_in = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int b0, n;
    rst = 1'b1;
    start_len_in = '0; start_valid_in = 1'b0; rd_data_in = '0;
    rd_data_valid_in = 1'b0; base_rdy_in = 1'b0;
    busy = 0; doneExpect = 0; startTaken = 0; prevValid = 0; togg = 0;
    curBeatsLeft = 0; beatsTotal = 0; cmdsDone = 0; cycle = 0; firstHs = -1; lastHs = 0;
    rdyMode = 0; validMode = 0; beatDelay = 0; lastBeatsSeen = 0; holdCnt = 0;
    #1;
    checkOutput("init_start_rdy", start_rdy_out, 1);
    checkOutput("init_rd_rdy", rd_data_rdy_out, 0);
    checkOutput("init_valid", base_valid_out, 0);
    checkOutput("init_base", base_out, 0);
    checkOutput("init_done", done_out, 0);
    #11;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single short command with a pinned beat
    b0 = beatsTotal;
    applyStimulus(5, 1, 1);
    checkOutput("len5_beats", beatsTotal - b0, 1);

    // Two back-to-back beats must drain with no bubble
    b0 = beatsTotal; firstHs = -1;
    applyStimulus(256, 1, 0);
    checkOutput("len256_beats", beatsTotal - b0, 2);
    checkOutput("len256_no_bubble", lastHs - firstHs, 255);

    // Toggling ready and a delayed second beat
    rdyMode = 1; beatDelay = 10; b0 = beatsTotal;
    applyStimulus(130, 1, 0);
    checkOutput("len130_beats", beatsTotal - b0, 2);
    checkOutput("len130_beatq_empty", beatQ.size(), 0);
    beatDelay = 0; rdyMode = 0;

    // Zero-length command then a one-base command
    b0 = beatsTotal;
    applyStimulus(0, 1, 0);
    checkOutput("len0_beats", beatsTotal - b0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("len1_beats", beatsTotal - b0, 1);

    // Asynchronous reset in the middle of a drain
    rdyMode = 2; validMode = 1;
    applyStimulus(200, 0, 0);
    n = 0;
    while (!base_valid_out && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reach_drain", base_valid_out, 1);
    repeat (20) @(posedge clk);
    doReset();
    applyStimulus(3, 1, 0);

    // Command queued while another is in flight
    applyStimulus(300, 0, 0);
    applyStimulus(77, 1, 0);

    // Randomized commands
    repeat (12) begin
      rdyMode   = $urandom_range(2, 0);
      validMode = $urandom_range(1, 0);
      beatDelay = $urandom_range(3, 0);
      applyStimulus(($urandom_range(7, 0) == 0) ? 0 : $urandom_range(400, 1), 1, 0);
    end

    // Counter totals for a known command mix
    rdyMode = 0; validMode = 0; beatDelay = 0;
    doReset();
    applyStimulus(1, 1, 0);
    applyStimulus(128, 1, 0);
    applyStimulus(129, 1, 0);
    checkOutput("mix_beats", beatsTotal, 4);
`ifdef REF_BEAT_UNPACKER_STATS_EN
    checkOutput("mix_stat_beats", stat_beats_out, 4);
    checkOutput("mix_stat_cmds", stat_cmds_out, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL global_timeout actual=%0t limit=5000000", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
